fifo_drain_ctrl: RTL and testbench
==================================

Name: fifo_drain_ctrl

Overview:
Read-side consumer for the async FIFO, running entirely in the read clock domain. It watches `rempty` and issues `rinc` pops, capturing `rdata` into a small internal skid buffer. It then presents the words on a valid/ready output stream with full throughput under back-pressure, plus an enable/stop handshake and a transfer counter for the downstream datapath and the bench scoreboard.

Parameters:
DSIZE, 8, data width; matches FIFO `rdata`.
BUF_DEPTH, 2, skid buffer entries; power of 2, at least 2.
CNT_W, 16, width of the transferred-word counter.

Ports:
rclk  in  1  read-domain clock; all logic is on its rising edge.
rrst  in  1  synchronous active-low reset; sampled on `rclk`.
en  in  1  1 = drain the FIFO; 0 = request a graceful stop.
rempty  in  1  FIFO empty flag (read domain).
rdata  in  DSIZE  FIFO read data; show-ahead, valid whenever `rempty`=0.
rinc  out  1  FIFO pop strobe.
out_data  out  DSIZE  stream data.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready from the consumer.
busy  out  1  high in RUN or STOP_PEND.
word_cnt  out  CNT_W  count of completed output handshakes, wrapping.

Behaviour:
- Reset: synchronous, active-low, on the `rclk` rising edge when `rrst`=0. After reset:
  - `rinc`=0, `out_valid`=0, `out_data`=0, `busy`=0, `word_cnt`=0;
  - buffer emptied; state is IDLE.
- Reset mid-operation:
  - buffered words are discarded;
  - `rinc` is low in the reset cycle;
  - no FIFO pop occurs while `rrst`=0.
- FIFO is show-ahead: a pop captures `rdata` on the same edge that `rinc` is sampled high. There is no read latency.
- rinc (combinational): `rinc` = (state==RUN) && !`rempty` && (cnt<BUF_DEPTH || (`out_valid` && `out_ready`)).
  - `rinc` is never asserted while `rempty`=1.
  - Buffer overflow is impossible.
- Skid buffer:
  - circular, with read pointer, write pointer and count; pointers wrap modulo BUF_DEPTH;
  - push on `rinc`, pop on `out_valid` && `out_ready`;
  - simultaneous push and pop leaves the count unchanged;
  - `out_valid` = (cnt!=0); `out_data` = head entry, registered storage;
  - `out_data` and `out_valid` are stable while `out_valid`=1 && `out_ready`=0.
- Throughput: with `rempty`=0 and `out_ready`=1 continuously, one word per cycle. First `out_valid` is 1 cycle after the first `rinc`.
- word_cnt: increments on each output handshake; wraps from 2^CNT_W-1 to 0.
- FSM states: IDLE, RUN, STOP_PEND.
  - IDLE → RUN when `en`=1.
  - RUN → STOP_PEND when `en`=0. No new `rinc` from that cycle onward.
  - STOP_PEND → IDLE when cnt==0 and no handshake is in flight.
  - STOP_PEND → RUN if `en` returns to 1 before the buffer drains. Buffered data is preserved.
  - In IDLE the buffer is empty and `rinc`=0.
- Boundaries:
  - `rempty` rising while the buffer is non-empty: the buffer continues to drain.
  - `out_ready`=0 with the buffer full: `rinc`=0 and the FIFO backs up. The upstream `wfull` behaviour is the FIFO's concern.
  - `en` toggled while in IDLE with an empty FIFO: no pops.

Decomposition:
- Shared package `fifo_pkg`:
  - DSIZE default;
  - FSM state enum `drain_state_e` {IDLE, RUN, STOP_PEND};
  - `localparam` PTR_W = $clog2(BUF_DEPTH).
- One sub-module, `skid_buf`: the circular buffer with count, full and empty, parameterised by DSIZE and BUF_DEPTH.
- Top module holds the FSM, the `rinc` logic and `word_cnt`.

Test Plan:
1. Reset hold: `rrst`=0 for 3 cycles with `rempty`=0 and `en`=1. Required: `rinc`=0, `out_valid`=0, `word_cnt`=0 throughout.
2. Streaming: write 0x01..0x10 into the FIFO, then `en`=1 and `out_ready`=1. Required:
   - 16 consecutive `rinc` pulses;
   - `out_data` = 0x01..0x10 in order, one per cycle;
   - `word_cnt`=16 at the end.
3. Back-pressure: 8 words queued, `out_ready`=0 for 10 cycles. Required:
   - exactly 2 pops, then `rinc`=0;
   - `out_data`=first word, held stable;
   - release `out_ready` → remaining 6 words pop; all 8 delivered in order with no loss or duplication.
4. Graceful stop: `en`=0 while 2 words are buffered and `out_ready`=1. Required:
   - no further `rinc`;
   - the 2 words are delivered;
   - `busy` falls 1 cycle after the last handshake; FIFO still holds the remainder.
5. Empty boundary: FIFO goes empty mid-stream, `en`=1. Required: `rinc`=0 while `rempty`=1; a refill of 0xA5 is delivered exactly once.
6. Wrap: CNT_W=4, 18 transfers. Required: `word_cnt`=2. Also check mid-stream reset: buffer cleared and `out_valid`=0 on the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing for the FIFO read-side drain controller.
// Holds the data width default, skid depth default and FSM state encoding.
package fifo_pkg;

  localparam int DSIZE_DEF     = 8;
  localparam int BUF_DEPTH_DEF = 2;
  localparam int CNT_W_DEF     = 16;
  localparam int PTR_W         = $clog2(BUF_DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fifo_drain_if.sv
// fifo_drain_if: FIFO read port (rempty/rdata/rinc) plus valid/ready stream.
// master = drain controller side, slave = FIFO + downstream consumer side.
interface fifo_drain_if
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
);

  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  rempty,
    input  rdata,
    input  out_ready,
    output rinc,
    output out_data,
    output out_valid
  );

  modport slave (
    output rempty,
    output rdata,
    output out_ready,
    input  rinc,
    input  out_data,
    input  out_valid
  );

endinterface

// File: rtl/fifo_drain_ctrl_skid_buf.sv
// skid_buf: circular buffer with count; ports clk/rst_n (sync), push_i,
// pop_i, data_i in; data_o (head entry), full_o, empty_o out.
module skid_buf
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DSIZE-1:0] data_i,
  output logic [DSIZE-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [DSIZE-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally since BUF_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(BUF_DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops a show-ahead FIFO into a skid buffer and streams it.
// Ports: rclk, rrst (sync low), en, bus (FIFO read + stream), busy, word_cnt.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DSIZE_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  fifo_drain_if.master     bus,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  drain_state_e     state_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full;
  logic             empty;
  logic             hs;
  logic             rinc;

  assign hs = !empty && bus.out_ready;

  // A pop is allowed into a full buffer when the head leaves the same cycle.
  // Gating on en stops pops in the very cycle a stop is requested;
  // gating on rrst keeps the FIFO untouched while in reset.
  assign rinc = rrst && en && (state_q == RUN) && !bus.rempty
             && (!full || hs);

  skid_buf #(
    .DSIZE     (DSIZE),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (rclk),
    .rst_n   (rrst),
    .push_i  (rinc),
    .pop_i   (hs),
    .data_i  (bus.rdata),
    .data_o  (bus.out_data),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge rclk) begin
    if (!rrst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state_q <= STOP_PEND;
          end
        end
        STOP_PEND: begin
          if (en) begin
            state_q <= RUN;
          end else if (empty) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rinc      = rinc;
  assign bus.out_valid = !empty;
  assign busy          = busy_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed bench with a FIFO model and output scoreboard.
// A second instance with a 4-bit counter runs in lockstep for the wrap case.
module tb_fifo_drain_ctrl;

  logic rclk;
  logic rrst;
  logic en;
  logic busy;
  logic busy4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  fifo_drain_if #(.DSIZE(8)) bus ();
  fifo_drain_if #(.DSIZE(8)) bus4 ();

  assign bus4.rempty    = bus.rempty;
  assign bus4.rdata     = bus.rdata;
  assign bus4.out_ready = bus.out_ready;

  fifo_drain_ctrl #(
    .DSIZE(8), .BUF_DEPTH(2), .CNT_W(16)
  ) dut (
    .rclk(rclk), .rrst(rrst), .en(en), .bus(bus),
    .busy(busy), .word_cnt(word_cnt)
  );

  fifo_drain_ctrl #(
    .DSIZE(8), .BUF_DEPTH(2), .CNT_W(4)
  ) dut4 (
    .rclk(rclk), .rrst(rrst), .en(en), .bus(bus4),
    .busy(busy4), .word_cnt(word_cnt4)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int hs_n = 0;

  task automatic refresh();
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic put(input logic [7:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    refresh();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic wait_hs(input int target, input int budget,
                         input string tag);
    int n;
    n = 0;
    while (hs_n < target && n < budget) begin
      @(negedge rclk);
      n++;
    end
    chk(tag, 32'(hs_n), 32'(target));
  endtask

  // FIFO model and output scoreboard, sampled at the rising edge.
  bit         pop_s;
  bit         hs_s;
  logic [7:0] d_s;
  logic [7:0] e_s;

  always @(posedge rclk) begin
    pop_s = (bus.rinc === 1'b1);
    hs_s  = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1)
         && (rrst === 1'b1);
    d_s   = bus.out_data;
    #1;
    if (pop_s) begin
      pops++;
      checks++;
      assert (fifo_q.size() != 0) else begin
        errors++;
        $error("FAIL pop_when_empty observed=empty expected=nonempty");
      end
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (hs_s) begin
      hs_n++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL sb_extra observed=%0h expected=none", d_s);
      end else begin
        e_s = exp_q.pop_front();
        assert (d_s === e_s) else begin
          errors++;
          $error("FAIL sb_data observed=%0h expected=%0h", d_s, e_s);
        end
      end
    end
    refresh();
  end

  int p0;
  int h0;

  initial begin
    rrst = 1'b0;
    en = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) put(8'(i));

    // 1: reset hold
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      chk("rst_rinc", 32'(bus.rinc), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_cnt", 32'(word_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    chk("rst_no_pop", 32'(pops), 0);

    // 2: streaming 0x01..0x10
    rrst = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge rclk);
      chk("st_rinc", 32'(bus.rinc), 32'(k <= 16));
      chk("st_valid", 32'(bus.out_valid), 32'(k >= 2 && k <= 17));
      if (k >= 2 && k <= 17)
        chk("st_data", 32'(bus.out_data), 32'(k - 1));
    end
    chk("st_pops", 32'(pops), 16);
    chk("st_cnt", 32'(word_cnt), 16);
    chk("st_cnt4", 32'(word_cnt4), 0);

    // 3: back-pressure with 8 words queued
    bus.out_ready = 1'b0;
    p0 = pops;
    h0 = hs_n;
    for (int i = 0; i < 8; i++) put(8'h21 + 8'(i));
    for (int i = 1; i <= 10; i++) begin
      @(negedge rclk);
      chk("bp_rinc", 32'(bus.rinc), 32'(i == 1));
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_hold", 32'(bus.out_data), 32'h21);
    end
    chk("bp_pops", 32'(pops - p0), 2);
    bus.out_ready = 1'b1;
    wait_hs(h0 + 8, 30, "bp_drain");
    chk("bp_all_pops", 32'(pops - p0), 8);

    // 4: graceful stop with a full buffer
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(8'h31 + 8'(i));
    cyc(4);
    chk("gs_full_rinc", 32'(bus.rinc), 0);
    p0 = pops;
    h0 = hs_n;
    en = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("gs_rinc0", 32'(bus.rinc), 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge rclk);
      chk("gs_rinc", 32'(bus.rinc), 0);
      chk("gs_busy", 32'(busy), 32'(i <= 2));
      chk("gs_valid", 32'(bus.out_valid), 32'(i == 1));
    end
    chk("gs_hs", 32'(hs_n - h0), 2);
    chk("gs_pops", 32'(pops - p0), 0);
    chk("gs_fifo_left", 32'(fifo_q.size()), 4);

    // 5: FIFO runs empty mid-stream, then a single refill
    en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (fifo_q.size() == 0 && bus.out_valid === 1'b0) break;
      @(negedge rclk);
    end
    chk("em_drained", 32'(fifo_q.size() == 0 && bus.out_valid === 1'b0), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge rclk);
      chk("em_rinc", 32'(bus.rinc), 0);
      chk("em_valid", 32'(bus.out_valid), 0);
    end
    h0 = hs_n;
    put(8'hA5);
    wait_hs(h0 + 1, 10, "em_refill");
    cyc(4);
    chk("em_once", 32'(hs_n - h0), 1);
    chk("em_sb_empty", 32'(exp_q.size()), 0);

    // en toggled in IDLE with an empty FIFO
    en = 1'b0;
    cyc(3);
    chk("id_busy", 32'(busy), 0);
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 0);
      cyc(1);
    end
    en = 1'b0;
    cyc(3);
    chk("id_pops", 32'(pops - p0), 0);
    chk("id_busy_end", 32'(busy), 0);

    // 6: counter wrap on the 4-bit instance
    rrst = 1'b0;
    cyc(1);
    chk("wr_rst_cnt", 32'(word_cnt), 0);
    chk("wr_rst_cnt4", 32'(word_cnt4), 0);
    rrst = 1'b1;
    en = 1'b1;
    h0 = hs_n;
    for (int i = 0; i < 18; i++) put(8'h40 + 8'(i));
    wait_hs(h0 + 18, 40, "wr_done");
    chk("wr_cnt4", 32'(word_cnt4), 2);
    chk("wr_cnt16", 32'(word_cnt), 18);

    // mid-stream reset with a full buffer
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(8'h60 + 8'(i));
    cyc(3);
    chk("mr_pre_valid", 32'(bus.out_valid), 1);
    p0 = pops;
    rrst = 1'b0;
    #1;
    chk("mr_rinc_rst", 32'(bus.rinc), 0);
    @(negedge rclk);
    chk("mr_valid", 32'(bus.out_valid), 0);
    chk("mr_cnt", 32'(word_cnt), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rinc", 32'(bus.rinc), 0);
    chk("mr_no_pop", 32'(pops - p0), 0);
    fifo_q.delete();
    exp_q.delete();
    refresh();
    rrst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      chk("mr_post_valid", 32'(bus.out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
